// File: rtl/spi_link_ctrl_if.sv
// spi_link_ctrl_if
// Bundles every non-clock signal of spi_link_ctrl.
//   SPI side      : word_done, rx_word (to controller), tx_word (from controller)
//   Requester A/B : a_req/b_req, a_word/b_word (to controller), a_ack/b_ack (from controller)
//   Status        : x_coor, y_coor, coor_valid, link_up, drop_cnt, overrun (from controller)
// Modports:
//   slave  - the controller's view (spi_link_ctrl)
//   master - the environment's view (SPI word engine, requesters, status consumers)
interface spi_link_ctrl_if;
  logic        word_done;
  logic [31:0] rx_word;
  logic [31:0] tx_word;
  logic        a_req;
  logic        b_req;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic        a_ack;
  logic        b_ack;
  logic [15:0] x_coor;
  logic [15:0] y_coor;
  logic        coor_valid;
  logic        link_up;
  logic [7:0]  drop_cnt;
  logic        overrun;

  modport slave (
    input  word_done, rx_word, a_req, b_req, a_word, b_word,
    output tx_word, a_ack, b_ack, x_coor, y_coor, coor_valid,
           link_up, drop_cnt, overrun
  );

  modport master (
    output word_done, rx_word, a_req, b_req, a_word, b_word,
    input  tx_word, a_ack, b_ack, x_coor, y_coor, coor_valid,
           link_up, drop_cnt, overrun
  );
endinterface

// File: rtl/spi_link_ctrl.sv
// spi_link_ctrl
// Sequences the 32-bit SPI slave word interface. Every completed frame is
// decoded into cursor coordinates (or counted as dropped if the line was
// idle-high), and the next transmit word is loaded from a round-robin grant
// between requester A (sample stream) and requester B (status).
//
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - spi_link_ctrl_if.slave (SPI word side, requesters, status outputs)
//
// Parameters:
//   FILL_WORD   - transmitted when no requester is pending
//   TIMEOUT_CYC - S_WAIT cycles without word_done before link_up drops
//
// Build option: define SPI_LINK_WATCHDOG_EN to include the link-health
// watchdog. Without it link_up is set by the first valid word and held
// until reset, and TIMEOUT_CYC has no effect.
module spi_link_ctrl #(
  parameter logic [31:0] FILL_WORD   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input logic            clk,
  input logic            reset,
  spi_link_ctrl_if.slave bus
);

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        pend_q, pend_d;      // frame ended while loading: skip the wait
  logic        last_b_q, last_b_d;  // 1 = B was granted most recently
  logic [31:0] tx_word_q, tx_word_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic [15:0] x_coor_q, x_coor_d;
  logic [15:0] y_coor_q, y_coor_d;
  logic        coor_valid_q, coor_valid_d;
  logic        link_up_q, link_up_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;
  logic        overrun_q, overrun_d;

  logic rx_idle;
  logic grant_a;
  logic grant_b;

  // An all-ones word means the master was absent (MISO/MOSI floating high).
  assign rx_idle = (bus.rx_word == 32'hFFFF_FFFF);

  // B wins only when A is absent or A was the last one served.
  assign grant_a = bus.a_req && (!bus.b_req || last_b_q);
  assign grant_b = bus.b_req && !grant_a;

`ifdef SPI_LINK_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    last_b_d     = last_b_q;
    tx_word_d    = tx_word_q;
    a_ack_d      = 1'b0;
    b_ack_d      = 1'b0;
    x_coor_d     = x_coor_q;
    y_coor_d     = y_coor_q;
    coor_valid_d = 1'b0;
    link_up_d    = link_up_q;
    drop_cnt_d   = drop_cnt_q;
    overrun_d    = overrun_q;

    // Receive path runs regardless of the transmit state.
    if (bus.word_done) begin
      if (rx_idle) begin
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end else begin
        x_coor_d     = bus.rx_word[31:16];
        y_coor_d     = bus.rx_word[15:0];
        coor_valid_d = 1'b1;
        link_up_d    = 1'b1;
      end
    end

`ifdef SPI_LINK_WATCHDOG_EN
    // Counts consecutive quiet S_WAIT cycles; parks at the last value so
    // link_up stays low until traffic resumes.
    wd_cnt_d = wd_cnt_q;
    if (bus.word_done || (state_q == S_LOAD)) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q == WD_LAST) begin
      link_up_d = 1'b0;
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
`endif

    case (state_q)
      S_LOAD: begin
        if (grant_a) begin
          tx_word_d = bus.a_word;
          a_ack_d   = 1'b1;
          last_b_d  = 1'b0;
        end else if (grant_b) begin
          tx_word_d = bus.b_word;
          b_ack_d   = 1'b1;
          last_b_d  = 1'b1;
        end else begin
          tx_word_d = FILL_WORD;
        end
        // A frame finishing here has already consumed the old tx_word, so
        // the next load must happen without waiting for another frame.
        if (bus.word_done) begin
          overrun_d = 1'b1;
          pend_d    = 1'b1;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.word_done || pend_q) begin
          pend_d  = 1'b0;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_LOAD;
      pend_q       <= 1'b0;
      last_b_q     <= 1'b1;
      tx_word_q    <= FILL_WORD;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      x_coor_q     <= 16'h0000;
      y_coor_q     <= 16'h0000;
      coor_valid_q <= 1'b0;
      link_up_q    <= 1'b0;
      drop_cnt_q   <= 8'h00;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      last_b_q     <= last_b_d;
      tx_word_q    <= tx_word_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      x_coor_q     <= x_coor_d;
      y_coor_q     <= y_coor_d;
      coor_valid_q <= coor_valid_d;
      link_up_q    <= link_up_d;
      drop_cnt_q   <= drop_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

`ifdef SPI_LINK_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`endif

  assign bus.tx_word    = tx_word_q;
  assign bus.a_ack      = a_ack_q;
  assign bus.b_ack      = b_ack_q;
  assign bus.x_coor     = x_coor_q;
  assign bus.y_coor     = y_coor_q;
  assign bus.coor_valid = coor_valid_q;
  assign bus.link_up    = link_up_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_link_ctrl.sv
// tb_spi_link_ctrl
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model tracks what every output must be and is compared
// with the DUT on each falling edge.
module tb_spi_link_ctrl;

  localparam logic [31:0] FILL = 32'h0000_0000;
  localparam int unsigned TO   = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_link_ctrl_if bus();

  spi_link_ctrl #(
    .FILL_WORD   (FILL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  int n_txn   = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_tx;
  logic        m_aack, m_back, m_cv, m_link, m_ovr;
  logic [15:0] m_x, m_y;
  int          m_drop;
  bit          m_loading;     // this edge is the one that picks the next tx word
  bit          m_skip_wait;   // a frame landed during loading
  bit          m_last_was_b;
  int          m_quiet;       // consecutive waiting cycles with no frame

  task automatic model_step();
    if (reset) begin
      m_tx = FILL; m_aack = 0; m_back = 0; m_cv = 0; m_link = 0; m_ovr = 0;
      m_x = 0; m_y = 0; m_drop = 0;
      m_loading = 1; m_skip_wait = 0; m_last_was_b = 1; m_quiet = 0;
      return;
    end
    m_cv = 0; m_aack = 0; m_back = 0;
    if (bus.word_done) begin
      n_txn++;
      $display("txn %0d rx_word=%h", n_txn, bus.rx_word);
      if (bus.rx_word == 32'hFFFF_FFFF) begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      end else begin
        m_x = bus.rx_word[31:16];
        m_y = bus.rx_word[15:0];
        m_cv = 1; m_link = 1;
      end
    end
`ifdef SPI_LINK_WATCHDOG_EN
    if (bus.word_done || m_loading) m_quiet = 0;
    else if (m_quiet + 1 >= int'(TO)) m_link = 0;
    else m_quiet++;
`endif
    if (m_loading) begin
      if (bus.a_req && bus.b_req) begin
        if (m_last_was_b) begin m_tx = bus.a_word; m_aack = 1; m_last_was_b = 0; end
        else              begin m_tx = bus.b_word; m_back = 1; m_last_was_b = 1; end
      end else if (bus.a_req) begin
        m_tx = bus.a_word; m_aack = 1; m_last_was_b = 0;
      end else if (bus.b_req) begin
        m_tx = bus.b_word; m_back = 1; m_last_was_b = 1;
      end else begin
        m_tx = FILL;
      end
      if (bus.word_done) begin m_ovr = 1; m_skip_wait = 1; end
      m_loading = 0;
    end else if (bus.word_done || m_skip_wait) begin
      m_loading = 1; m_skip_wait = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("tx_word",    bus.tx_word,            m_tx);
      check("a_ack",      32'(bus.a_ack),         32'(m_aack));
      check("b_ack",      32'(bus.b_ack),         32'(m_back));
      check("x_coor",     32'(bus.x_coor),        32'(m_x));
      check("y_coor",     32'(bus.y_coor),        32'(m_y));
      check("coor_valid", 32'(bus.coor_valid),    32'(m_cv));
      check("link_up",    32'(bus.link_up),       32'(m_link));
      check("drop_cnt",   32'(bus.drop_cnt),      32'(m_drop));
      check("overrun",    32'(bus.overrun),       32'(m_ovr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_wd(input logic [31:0] w);
    @(negedge clk);
    bus.word_done = 1'b1;
    bus.rx_word   = w;
    @(negedge clk);
    bus.word_done = 1'b0;
  endtask

  logic [31:0] exp_seq [3];
  bit          exp_is_a [3];
  int          gap;
  int          r;

  initial begin
    reset = 1'b1;
    bus.word_done = 0; bus.rx_word = 0;
    bus.a_req = 0; bus.b_req = 0; bus.a_word = 0; bus.b_word = 0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (3) @(negedge clk);

    // 1: first valid word, no requesters
    pulse_wd(32'h0123_0456);
    check("t1 x_coor",     32'(bus.x_coor),     32'h0000_0123);
    check("t1 y_coor",     32'(bus.y_coor),     32'h0000_0456);
    check("t1 coor_valid", 32'(bus.coor_valid), 32'd1);
    check("t1 link_up",    32'(bus.link_up),    32'd1);
    @(negedge clk);
    check("t1 tx_word", bus.tx_word, 32'h0000_0000);
    check("t1 acks",    32'({bus.a_ack, bus.b_ack}), 32'd0);
    repeat (4) @(negedge clk);

    // 2: both requesters held -> A, B, A
    exp_seq[0] = 32'hAAAA_0001; exp_is_a[0] = 1;
    exp_seq[1] = 32'hBBBB_0002; exp_is_a[1] = 0;
    exp_seq[2] = 32'hAAAA_0001; exp_is_a[2] = 1;
    bus.a_req = 1; bus.a_word = 32'hAAAA_0001;
    bus.b_req = 1; bus.b_word = 32'hBBBB_0002;
    for (int i = 0; i < 3; i++) begin
      pulse_wd(32'h1111_2222);
      @(negedge clk);
      check("t2 tx_word", bus.tx_word, exp_seq[i]);
      check("t2 a_ack", 32'(bus.a_ack), 32'(exp_is_a[i]));
      check("t2 b_ack", 32'(bus.b_ack), 32'(!exp_is_a[i]));
      @(negedge clk);
      check("t2 ack width", 32'({bus.a_ack, bus.b_ack}), 32'd0);
      repeat (2) @(negedge clk);
    end
    bus.a_req = 0; bus.b_req = 0;
    repeat (4) @(negedge clk);

    // 3: idle-high frames saturate the drop counter
    for (int i = 0; i < 300; i++) begin
      pulse_wd(32'hFFFF_FFFF);
      repeat (2) @(negedge clk);
    end
    check("t3 drop_cnt", 32'(bus.drop_cnt), 32'd255);
    check("t3 x_coor",   32'(bus.x_coor),   32'h0000_1111);
    check("t3 y_coor",   32'(bus.y_coor),   32'h0000_2222);

    // 4: back-to-back frames -> overrun and immediate reload
    bus.a_req = 1; bus.a_word = 32'hA5A5_0003;
    @(negedge clk);
    bus.word_done = 1; bus.rx_word = 32'h0AAA_0BBB;
    @(negedge clk);
    bus.rx_word = 32'h0CCC_0DDD;
    @(negedge clk);
    bus.word_done = 0;
    check("t4 overrun", 32'(bus.overrun), 32'd1);
    check("t4 x_coor",  32'(bus.x_coor),  32'h0000_0CCC);
    check("t4 y_coor",  32'(bus.y_coor),  32'h0000_0DDD);
    check("t4 tx_word", bus.tx_word, 32'hA5A5_0003);
    check("t4 a_ack",   32'(bus.a_ack), 32'd1);
    bus.a_word = 32'hA5A5_0004;
    @(negedge clk);
    check("t4 a_ack low", 32'(bus.a_ack), 32'd0);
    @(negedge clk);
    check("t4 reload tx_word", bus.tx_word, 32'hA5A5_0004);
    check("t4 reload a_ack",   32'(bus.a_ack), 32'd1);
    bus.a_req = 0;
    repeat (4) @(negedge clk);

    // 5: watchdog
    pulse_wd(32'h0042_0043);
    repeat (16) @(negedge clk);
    check("t5 link before timeout", 32'(bus.link_up), 32'd1);
    @(negedge clk);
`ifdef SPI_LINK_WATCHDOG_EN
    check("t5 link at timeout", 32'(bus.link_up), 32'd0);
`else
    check("t5 link at timeout", 32'(bus.link_up), 32'd1);
`endif
    repeat (3) @(negedge clk);

    // 6: reset while A pending in S_LOAD
    bus.a_req = 1; bus.a_word = 32'h5A5A_0006;
    pulse_wd(32'h0101_0202);
    reset = 1'b1;
    @(negedge clk);
    check("t6 a_ack in reset", 32'(bus.a_ack), 32'd0);
    check("t6 tx_word in reset", bus.tx_word, FILL);
    check("t6 link in reset", 32'(bus.link_up), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("t6 tx_word after reset", bus.tx_word, 32'h5A5A_0006);
    check("t6 a_ack after reset", 32'(bus.a_ack), 32'd1);
    bus.a_req = 0;
    repeat (4) @(negedge clk);

    // 7: randomized traffic
    gap = 3;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      bus.word_done = 0;
      reset = ($urandom_range(0, 599) == 0);
      if (bus.a_ack) begin
        if ($urandom_range(0, 1) == 0) bus.a_req = 0;
        else bus.a_word = $urandom;
      end else if (!bus.a_req && $urandom_range(0, 3) == 0) begin
        bus.a_req = 1; bus.a_word = $urandom;
      end
      if (bus.b_ack) begin
        if ($urandom_range(0, 1) == 0) bus.b_req = 0;
        else bus.b_word = $urandom;
      end else if (!bus.b_req && $urandom_range(0, 3) == 0) begin
        bus.b_req = 1; bus.b_word = $urandom;
      end
      if (gap == 0) begin
        bus.word_done = 1;
        bus.rx_word = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        r = int'($urandom_range(0, 29));
        if (r == 0)      gap = 0;
        else if (r == 1) gap = int'($urandom_range(20, 40));
        else             gap = int'($urandom_range(3, 8));
      end else begin
        gap--;
      end
    end
    @(negedge clk);
    bus.word_done = 0; reset = 0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_link_ctrl.md
# spi_link_ctrl

Clock-domain controller that sequences the 32-bit SPI slave word interface between the MCU link and the signal-processing datapath. On each completed frame it decodes the received word into cursor coordinates and reloads the next transmit word. The transmit word is granted round-robin to one of two on-chip requesters (A = sample stream, B = status). It also maintains a link-health watchdog and a dropped-word counter.

## Interface
Parameters:
- FILL_WORD, 32'h0000_0000, transmit word when no requester is pending
- TIMEOUT_CYC, 1000000, clk cycles in S_WAIT without word_done before link_up drops

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- word_done  in  1  one-cycle pulse: a 32-bit frame completed (already synchronized to clk)
- rx_word  in  32  received frame, valid when word_done=1
- tx_word  out  32  word presented to the SPI slave for the next frame
- a_req / b_req  in  1  requester wants a transmit slot; held until ack
- a_word / b_word  in  32  requester payload; stable while req=1
- a_ack / b_ack  out  1  one-cycle pulse: payload loaded into tx_word
- x_coor / y_coor  out  16  cursor coordinates, rx_word[31:16] / rx_word[15:0]
- coor_valid  out  1  one-cycle pulse: coordinates updated
- link_up  out  1  link healthy
- drop_cnt  out  8  saturating count of discarded rx words
- overrun  out  1  sticky: word_done arrived during S_LOAD

## Operation
- States:
  - S_LOAD (entered from reset): arbitrate, load tx_word, then go to S_WAIT.
  - S_WAIT: wait for word_done, then go to S_LOAD.
- Arbitration in S_LOAD:
  - Only one request pending: grant it.
  - Both pending: grant the one not granted last. The last-grant pointer resets to B, so A wins first.
  - Neither pending: tx_word <= FILL_WORD; no ack; pointer unchanged.
  - Grant: tx_word <= granted word, and that requester's ack pulses.
- Rx capture runs every cycle, independent of state. When word_done=1:
  - rx_word == 32'hFFFF_FFFF (idle/floating master): discard; drop_cnt += 1, saturating at 255.
  - Any other value: x_coor/y_coor load; coor_valid pulses; link_up <= 1.
- tx_word is never changed in S_WAIT.
- word_done during S_LOAD:
  - The rx word is still processed.
  - overrun is set and stays set until reset.
  - A pending flag is set, so S_WAIT returns to S_LOAD on the next cycle without waiting for another word_done.
- Watchdog:
  - Counter clears on word_done and in S_LOAD; increments each S_WAIT cycle.
  - At count == TIMEOUT_CYC-1: link_up <= 0 and the counter holds.
  - The loaded tx_word is kept.
- Reset values: tx_word=FILL_WORD, acks=0, x_coor=y_coor=0, coor_valid=0, link_up=0, drop_cnt=0, overrun=0, state=S_LOAD, pointer=B.
- Reset mid-operation discards the pending grant: no ack is issued, and the requester must keep req asserted.

## Timing
- All outputs are registered.
- word_done sampled at edge t:
  - x_coor, y_coor, coor_valid, drop_cnt and link_up update visible in cycle t+1.
  - State is S_LOAD in cycle t+1.
  - tx_word and ack visible in cycle t+2.
- Requester req/word are sampled at the clk edge ending S_LOAD. A req rising during S_WAIT waits for the next frame.
- Ack is exactly one cycle. Requester must drop req, or present a new word, in the cycle after ack.
- Transmit latency from word_done: 2 cycles. The SPI master must leave at least 3 clk cycles between frames.

## Configuration
- SPI_LINK_WATCHDOG_EN defined: watchdog counter present; link_up behaves as above.
- Undefined:
  - No counter logic; TIMEOUT_CYC is ignored.
  - link_up rises on the first valid rx word and stays 1 until reset.

## Test plan
- Reset, no requests, word_done with rx_word=32'h0123_0456 -> cycle+1: x_coor=16'h0123, y_coor=16'h0456, coor_valid=1, link_up=1; tx_word remains 32'h0000_0000; no ack.
- a_req and b_req both held (a_word=32'hAAAA_0001, b_word=32'hBBBB_0002), three word_done pulses -> tx_word sequence A, B, A; each ack one cycle; grant visible 2 cycles after word_done.
- 300 word_done pulses with rx_word=32'hFFFF_FFFF -> drop_cnt saturates at 255; coordinates unchanged; coor_valid never pulses.
- word_done on two consecutive cycles -> overrun=1; both rx words processed; the second frame triggers an immediate S_WAIT->S_LOAD.
- With SPI_LINK_WATCHDOG_EN and TIMEOUT_CYC=16: valid word, then idle -> link_up falls exactly 16 cycles after entering S_WAIT. Without the macro -> link_up stays 1.
- Assert reset while a_req is pending in S_LOAD -> no a_ack; tx_word=FILL_WORD; the grant occurs on the first S_LOAD after reset.
